// File: rtl/sumador_nibble_serial_if.sv
// ============================================================================
// sumador_nibble_serial_if : start/busy/done handshake and operand/result bus
//                            for the nibble-serial adder/subtractor.
// Revision 1.0
// ============================================================================
`default_nettype none

interface sumador_nibble_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] operandX;
  logic [WIDTH-1:0] operandY;
  logic             carry0;
  logic             subtract;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carryOut;
  logic             overflow;
  logic             zero;

  modport master (
    output start, operandX, operandY, carry0, subtract,
    input  busy, done, sum, carryOut, overflow, zero
  );

  modport slave (
    input  start, operandX, operandY, carry0, subtract,
    output busy, done, sum, carryOut, overflow, zero
  );
endinterface

`default_nettype wire

// File: rtl/sumador_nibble_serial.sv
// ============================================================================
// sumador_nibble_serial : WIDTH-bit add/subtract, one nibble per clock through
//                         a shared 4-bit ripple stage with a registered carry.
// Revision 1.0
// ============================================================================
`default_nettype none

module sumador_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sumador_nibble_serial_if.slave bus
);

  localparam int              NIB      = WIDTH / 4;
  localparam int              CW       = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(NIB - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [3:0]       nib_x, nib_y, nib_s;
  logic             nib_c4, nib_c3;
  logic [WIDTH-1:0] acc_w;

  // Shared 4-bit stage: select the active nibble and merge its result back.
  always_comb begin
    nib_x = '0;
    nib_y = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == CW'(n)) begin
        nib_x = x_q[n*4 +: 4];
        nib_y = y_q[n*4 +: 4];
      end
    end
    {nib_c4, nib_s} = {1'b0, nib_x} + {1'b0, nib_y} + {4'b0000, carry_q};
    nib_c3 = nib_x[3] ^ nib_y[3] ^ nib_s[3];
    acc_w  = acc_q;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == CW'(n)) begin
        acc_w[n*4 +: 4] = nib_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.operandX;
          y_d     = bus.subtract ? ~bus.operandY : bus.operandY;
          carry_d = bus.carry0 ^ bus.subtract;
          idx_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_w;
        carry_d = nib_c4;
        if (idx_q == LAST_IDX) begin
          // Results only become visible once the whole word is done.
          state_d = IDLE;
          idx_d   = '0;
          sum_d   = acc_w;
          cout_d  = nib_c4;
          ovf_d   = nib_c3 ^ nib_c4;
          zero_d  = (acc_w == '0);
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.carryOut = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

`default_nettype wire
